// File: rtl/pos_sweep_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pos_sweep_ctrl                                             |
// | Description : Exhaustive sweep sequencer for a 4-input combinational     |
// |               function. Drives all 16 input vectors, waits SETTLE_CYC    |
// |               cycles per vector, captures the function output into a     |
// |               truth table and counts maxterms (f = 0).                   |
// |               Optional macro TT_COMPARE_EN adds a check against an       |
// |               expected truth table (sticky mismatch + first fail index). |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pos_sweep_ctrl #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic        f_in,
`ifdef TT_COMPARE_EN
  input  logic [15:0] expected_tt,
  output logic        mismatch,
  output logic [3:0]  fail_idx,
`endif
  output logic [3:0]  vec_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt_out,
  output logic [4:0]  maxterm_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DRIVE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  // Settle counter value on the last DRIVE cycle of a vector
  localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYC - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_launch;
  logic        w_capture;
  logic [3:0]  r_idx;
  logic [3:0]  r_cnt;
  logic [15:0] r_tt;
  logic [4:0]  r_maxcnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode, datapath strobes and state-derived outputs
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_capture   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    vec_out     = 4'd0;
    case (r_state)
      S_IDLE: begin
        // abort has priority over a simultaneous start
        if (start && !abort) begin
          w_state_nxt = S_DRIVE;
          w_launch    = 1'b1;
        end
      end
      S_DRIVE: begin
        busy    = 1'b1;
        vec_out = r_idx;
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_SETTLE_LAST) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        busy    = 1'b1;
        vec_out = r_idx;
        if (abort) begin
          // sample of this vector is dropped
          w_state_nxt = S_IDLE;
        end else begin
          w_capture   = 1'b1;
          w_state_nxt = (r_idx == 4'd15) ? S_FINISH : S_DRIVE;
        end
      end
      S_FINISH: begin
        // an abort landing on the completion cycle cancels the pulse
        done        = !abort;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Vector index, settle counter and captured results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx    <= 4'd0;
      r_cnt    <= 4'd0;
      r_tt     <= 16'd0;
      r_maxcnt <= 5'd0;
    end else if (w_launch) begin
      r_idx    <= 4'd0;
      r_cnt    <= 4'd0;
      r_tt     <= 16'd0;
      r_maxcnt <= 5'd0;
    end else if (w_capture) begin
      r_tt[r_idx] <= f_in;
      r_maxcnt    <= r_maxcnt + {4'd0, ~f_in};
      r_cnt       <= 4'd0;
      // index stops at 15; the sweep ends in FINISH instead of wrapping
      if (r_idx != 4'd15) begin
        r_idx <= r_idx + 4'd1;
      end
    end else if ((r_state == S_DRIVE) && !abort) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign tt_out      = r_tt;
  assign maxterm_cnt = r_maxcnt;

`ifdef TT_COMPARE_EN
  logic [15:0] r_exp;
  logic        r_mismatch;
  logic [3:0]  r_fail_idx;

  // Latch the reference at launch and record the first differing index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp      <= 16'd0;
      r_mismatch <= 1'b0;
      r_fail_idx <= 4'd0;
    end else if (w_launch) begin
      r_exp      <= expected_tt;
      r_mismatch <= 1'b0;
      r_fail_idx <= 4'd0;
    end else if (w_capture && !r_mismatch && (f_in != r_exp[r_idx])) begin
      r_mismatch <= 1'b1;
      r_fail_idx <= r_idx;
    end
  end

  assign mismatch = r_mismatch;
  assign fail_idx = r_fail_idx;
`endif

endmodule
`default_nettype wire
